data_mem_arbiter: RTL and testbench

//   Shares the single-port data_memory between two requesters: R0 (CPU load/store)
//   and R1 (DMA/debug loader). Registers each granted command and drives the

---
 rtl/data_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory: one registered access per cycle.
// Build option: define ARB_FIXED_PRIO_EN for fixed R0 priority instead of round robin.
module data_mem_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  r0_req,
   input  logic                  r0_we,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   input  logic [DATA_WIDTH-1:0] r0_wdata,
   input  logic                  r1_req,
   input  logic                  r1_we,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   input  logic [DATA_WIDTH-1:0] r1_wdata,
   output logic                  r0_gnt,
   output logic                  r1_gnt,
   output logic [DATA_WIDTH-1:0] r0_rdata,
   output logic [DATA_WIDTH-1:0] r1_rdata,
   output logic                  r0_rvalid,
   output logic                  r1_rvalid,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   output logic                  mem_write,
   output logic                  mem_read,
   input  logic [DATA_WIDTH-1:0] mem_read_data
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic                  last_owner_q, last_owner_d;
   logic                  owner_q, owner_d;
   logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
   logic [DATA_WIDTH-1:0] mem_write_data_q, mem_write_data_d;
   logic                  mem_write_q, mem_write_d;
   logic                  mem_read_q, mem_read_d;
   logic [DATA_WIDTH-1:0] r0_rdata_q, r0_rdata_d;
   logic [DATA_WIDTH-1:0] r1_rdata_q, r1_rdata_d;
   logic                  r0_rvalid_q, r0_rvalid_d;
   logic                  r1_rvalid_q, r1_rvalid_d;
   logic                  gnt0_s, gnt1_s, any_gnt_s;

   // Grant decision; held low while reset is asserted so nothing is granted mid-reset.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (!rst_n) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else if (r0_req && r1_req) begin
`ifdef ARB_FIXED_PRIO_EN
         gnt0_s = 1'b1;
         gnt1_s = 1'b0;
`else
         // last_owner_q = 1 means R1 was served last, so R0 gets this tie
         gnt0_s = last_owner_q;
         gnt1_s = ~last_owner_q;
`endif
      end else begin
         gnt0_s = r0_req;
         gnt1_s = r1_req;
      end
   end

   assign any_gnt_s = gnt0_s | gnt1_s;

   // Next-state: latch the granted command and capture read data at the end of ACCESS.
   always_comb begin
      state_d          = IDLE;
      owner_d          = owner_q;
      last_owner_d     = last_owner_q;
      mem_address_d    = {ADDR_WIDTH{1'b0}};
      mem_write_data_d = {DATA_WIDTH{1'b0}};
      mem_write_d      = 1'b0;
      mem_read_d       = 1'b0;
      r0_rdata_d       = r0_rdata_q;
      r1_rdata_d       = r1_rdata_q;
      r0_rvalid_d      = 1'b0;
      r1_rvalid_d      = 1'b0;

      if (any_gnt_s) begin
         state_d      = ACCESS;
         owner_d      = gnt1_s;
         last_owner_d = gnt1_s;
         if (gnt1_s) begin
            mem_address_d    = r1_addr;
            mem_write_data_d = r1_wdata;
            mem_write_d      = r1_we;
            mem_read_d       = ~r1_we;
         end else begin
            mem_address_d    = r0_addr;
            mem_write_data_d = r0_wdata;
            mem_write_d      = r0_we;
            mem_read_d       = ~r0_we;
         end
      end else begin
         state_d = IDLE;
      end

      if ((state_q == ACCESS) && mem_read_q) begin
         if (owner_q) begin
            r1_rdata_d  = mem_read_data;
            r1_rvalid_d = 1'b1;
         end else begin
            r0_rdata_d  = mem_read_data;
            r0_rvalid_d = 1'b1;
         end
      end else begin
         r0_rvalid_d = 1'b0;
         r1_rvalid_d = 1'b0;
      end
   end

   // FSM and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         owner_q          <= 1'b0;
         last_owner_q     <= 1'b1;
         mem_address_q    <= {ADDR_WIDTH{1'b0}};
         mem_write_data_q <= {DATA_WIDTH{1'b0}};
         mem_write_q      <= 1'b0;
         mem_read_q       <= 1'b0;
         r0_rdata_q       <= {DATA_WIDTH{1'b0}};
         r1_rdata_q       <= {DATA_WIDTH{1'b0}};
         r0_rvalid_q      <= 1'b0;
         r1_rvalid_q      <= 1'b0;
      end else begin
         state_q          <= state_d;
         owner_q          <= owner_d;
         last_owner_q     <= last_owner_d;
         mem_address_q    <= mem_address_d;
         mem_write_data_q <= mem_write_data_d;
         mem_write_q      <= mem_write_d;
         mem_read_q       <= mem_read_d;
         r0_rdata_q       <= r0_rdata_d;
         r1_rdata_q       <= r1_rdata_d;
         r0_rvalid_q      <= r0_rvalid_d;
         r1_rvalid_q      <= r1_rvalid_d;
      end
   end

   assign r0_gnt         = gnt0_s;
   assign r1_gnt         = gnt1_s;
   assign r0_rdata       = r0_rdata_q;
   assign r1_rdata       = r1_rdata_q;
   assign r0_rvalid      = r0_rvalid_q;
   assign r1_rvalid      = r1_rvalid_q;
   assign mem_address    = mem_address_q;
   assign mem_write_data = mem_write_data_q;
   assign mem_write      = mem_write_q;
   assign mem_read       = mem_read_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural single-port memory attached.
module tb_data_mem_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       r0_req, r0_we, r1_req, r1_we;
   logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic       r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
   logic [7:0] r0_rdata, r1_rdata;
   logic [7:0] mem_address, mem_write_data, mem_read_data;
   logic       mem_write, mem_read;
   logic [7:0] mem_q [256];
   logic [5:0] exp_g0;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   // Memory: synchronous write, combinational read.
   always @(posedge clk) if (mem_write) mem_q[mem_address] <= mem_write_data;
   assign mem_read_data = mem_q[mem_address];

   data_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
      .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
      .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv0(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
      r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d;
   endtask

   task automatic drv1(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
      r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " r0_gnt"}, r0_gnt, 0);
      chk({tag, " r1_gnt"}, r1_gnt, 0);
      chk({tag, " r0_rvalid"}, r0_rvalid, 0);
      chk({tag, " r1_rvalid"}, r1_rvalid, 0);
      chk({tag, " mem_write"}, mem_write, 0);
      chk({tag, " mem_read"}, mem_read, 0);
      chk({tag, " mem_address"}, mem_address, 0);
      chk({tag, " mem_write_data"}, mem_write_data, 0);
      chk({tag, " r0_rdata"}, r0_rdata, 0);
      chk({tag, " r1_rdata"}, r1_rdata, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      drv0(1'b0, 1'b0, 8'h00, 8'h00);
      drv1(1'b1, 1'b0, 8'h00, 8'h00);
      #3;
      chk_idle_outputs("por");
      drv1(1'b0, 1'b0, 8'h00, 8'h00);
      tick();
      tick();
      rst_n = 1'b1;

      // Preload: R0 writes 0x05<=0x11, then R1 writes 0x00<=0xAA.
      drv0(1'b1, 1'b1, 8'h05, 8'h11);
      #1;
      chk("pre r0_gnt", r0_gnt, 1);
      tick();
      drv0(1'b0, 1'b0, 8'h00, 8'h00);
      drv1(1'b1, 1'b1, 8'h00, 8'hAA);
      #1;
      chk("pre r1_gnt", r1_gnt, 1);
      chk("pre wr05 mem_write", mem_write, 1);
      chk("pre wr05 mem_address", mem_address, 8'h05);
      chk("pre wr05 mem_write_data", mem_write_data, 8'h11);
      tick();
      drv1(1'b0, 1'b0, 8'h00, 8'h00);
      chk("pre wr00 mem_write_data", mem_write_data, 8'hAA);
      tick();
      chk("pre idle mem_write", mem_write, 0);
      chk("pre idle mem_address", mem_address, 0);

      // Tie: R0 read 0x00 vs R1 write 0x00<=0xDD; R0 wins and sees 0xAA.
      drv0(1'b1, 1'b0, 8'h00, 8'h00);
      drv1(1'b1, 1'b1, 8'h00, 8'hDD);
      #1;
      chk("tie r0_gnt", r0_gnt, 1);
      chk("tie r1_gnt", r1_gnt, 0);
      tick();
      drv0(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      chk("tie r1_gnt next", r1_gnt, 1);
      chk("tie mem_read", mem_read, 1);
      tick();
      drv1(1'b0, 1'b0, 8'h00, 8'h00);
      chk("tie r0_rvalid", r0_rvalid, 1);
      chk("tie r0_rdata", r0_rdata, 8'hAA);
      chk("tie mem_write", mem_write, 1);
      chk("tie mem_write_data", mem_write_data, 8'hDD);
      tick();
      chk("tie r0_rvalid drop", r0_rvalid, 0);
      chk("tie r1_rvalid", r1_rvalid, 0);
      drv0(1'b1, 1'b0, 8'h00, 8'h00);
      tick();
      drv0(1'b0, 1'b0, 8'h00, 8'h00);
      tick();
      chk("tie readback", r0_rdata, 8'hDD);

      // R0 write 0x10<=0xBB then read 0x10 back-to-back.
      drv0(1'b1, 1'b1, 8'h10, 8'hBB);
      #1;
      chk("rw wr gnt", r0_gnt, 1);
      tick();
      drv0(1'b1, 1'b0, 8'h10, 8'h00);
      #1;
      chk("rw rd gnt", r0_gnt, 1);
      tick();
      drv0(1'b0, 1'b0, 8'h00, 8'h00);
      chk("rw mem_read", mem_read, 1);
      chk("rw mem_address", mem_address, 8'h10);
      chk("rw r0_rvalid early", r0_rvalid, 0);
      tick();
      chk("rw r0_rvalid", r0_rvalid, 1);
      chk("rw r0_rdata", r0_rdata, 8'hBB);
      tick();
      chk("rw r0_rvalid drop", r0_rvalid, 0);
      chk("rw r0_rdata hold", r0_rdata, 8'hBB);

      // R1 read 0x10 so R1 is last owner going into the streaming test.
      drv1(1'b1, 1'b0, 8'h10, 8'h00);
      #1;
      chk("r1rd gnt", r1_gnt, 1);
      tick();
      drv1(1'b0, 1'b0, 8'h00, 8'h00);
      tick();
      chk("r1rd r1_rvalid", r1_rvalid, 1);
      chk("r1rd r1_rdata", r1_rdata, 8'hBB);
      chk("r1rd r0_rvalid", r0_rvalid, 0);

      // Both hold req for 6 cycles: R0 reads 0x10, R1 writes 0x20.
`ifdef ARB_FIXED_PRIO_EN
      exp_g0 = 6'b111111;
`else
      exp_g0 = 6'b010101;
`endif
      drv0(1'b1, 1'b0, 8'h10, 8'h00);
      drv1(1'b1, 1'b1, 8'h20, 8'h5A);
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("rr r0_gnt[%0d]", i), r0_gnt, exp_g0[i]);
         chk($sformatf("rr r1_gnt[%0d]", i), r1_gnt, !exp_g0[i]);
         if (i > 0) begin
            chk($sformatf("rr mem_read[%0d]", i), mem_read, exp_g0[i-1]);
            chk($sformatf("rr mem_write[%0d]", i), mem_write, !exp_g0[i-1]);
         end
         tick();
      end
      drv0(1'b0, 1'b0, 8'h00, 8'h00);
      drv1(1'b0, 1'b0, 8'h00, 8'h00);
      chk("rr mem_read last", mem_read, exp_g0[5]);
      chk("rr mem_write last", mem_write, !exp_g0[5]);
      tick();
      chk("rr idle mem_read", mem_read, 0);
      chk("rr idle mem_write", mem_write, 0);
      tick();

      // Hazard: R1 write 0xFF<=0xCC, R0 reads 0xFF the next cycle.
      drv1(1'b1, 1'b1, 8'hFF, 8'hCC);
      #1;
      chk("hz r1_gnt", r1_gnt, 1);
      tick();
      drv1(1'b0, 1'b0, 8'h00, 8'h00);
      drv0(1'b1, 1'b0, 8'hFF, 8'h00);
      #1;
      chk("hz r0_gnt", r0_gnt, 1);
      tick();
      drv0(1'b0, 1'b0, 8'h00, 8'h00);
      chk("hz r1_rvalid", r1_rvalid, 0);
      tick();
      chk("hz r0_rvalid", r0_rvalid, 1);
      chk("hz r0_rdata", r0_rdata, 8'hCC);
      chk("hz r1_rdata kept", r1_rdata, 8'hBB);
      tick();

      // Reset during a write ACCESS to 0x05 (0xEE): write must not commit.
      drv0(1'b1, 1'b1, 8'h05, 8'hEE);
      tick();
      drv0(1'b0, 1'b0, 8'h00, 8'h00);
      drv1(1'b1, 1'b0, 8'h30, 8'h00);
      chk("rst pre mem_write", mem_write, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("rst");
      drv1(1'b0, 1'b0, 8'h00, 8'h00);
      tick();
      rst_n = 1'b1;
      drv0(1'b1, 1'b0, 8'h05, 8'h00);
      #1;
      chk("rst rd gnt", r0_gnt, 1);
      tick();
      drv0(1'b0, 1'b0, 8'h00, 8'h00);
      tick();
      chk("rst rd r0_rvalid", r0_rvalid, 1);
      chk("rst rd r0_rdata", r0_rdata, 8'h11);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
